// File: rtl/controlador_atributos_n.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_atributos_n
//  Description : N saturating pet attributes updated on a divided-clock tick,
//                with pause, low-level alerts and sticky death detection.
//                Optional macro ALERTA_HISTERESE_EN registers the alerts with
//                hysteresis.
//  Revision    : 1.0 - initial release
// ============================================================================
module controlador_atributos_n #(
    parameter int                          N_ATRIB       = 3,
    parameter int                          LARGURA       = 8,
    parameter int                          MAX_VAL       = 100,
    parameter int                          VEL_SUBIDA    = 7,
    parameter int                          VEL_DESCIDA   = 1,
    parameter int                          DIV_TICK      = 65536,
    parameter logic [N_ATRIB*LARGURA-1:0]  VAL_INICIAL   = {8'd50, 8'd70, 8'd80},
    parameter int                          LIMIAR_ALERTA = 20,
    parameter int                          HIST_ALERTA   = 10,
    parameter int                          TICKS_MORTE   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_ATRIB-1:0]           acao,
    input  logic                         pausa,
    output logic [N_ATRIB*LARGURA-1:0]   atributos,
    output logic [N_ATRIB-1:0]           alerta,
    output logic                         morto,
    output logic                         tick
);

    localparam int                 c_div_w     = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam int                 c_cz_w      = $clog2(TICKS_MORTE + 1);
    localparam logic [c_div_w-1:0] c_div_max   = c_div_w'(DIV_TICK - 1);
    localparam logic [c_cz_w-1:0]  c_ticks     = c_cz_w'(TICKS_MORTE);
    localparam logic [c_cz_w-1:0]  c_ticks_m1  = c_cz_w'(TICKS_MORTE - 1);
    localparam logic [LARGURA:0]   c_sub_ext   = (LARGURA+1)'(VEL_SUBIDA);
    localparam logic [LARGURA:0]   c_max_ext   = (LARGURA+1)'(MAX_VAL);
    localparam logic [LARGURA-1:0] c_max       = LARGURA'(MAX_VAL);
    localparam logic [LARGURA-1:0] c_desc      = LARGURA'(VEL_DESCIDA);
    localparam logic [LARGURA:0]   c_lim_ext   = (LARGURA+1)'(LIMIAR_ALERTA);

    logic [c_div_w-1:0] r_div;
    logic [c_cz_w-1:0]  r_cz;
    logic               r_morto;
    logic               w_tick;
    logic               w_atualiza;
    logic               w_acao_valida;
    logic [N_ATRIB-1:0] w_zero;

    assign w_tick        = (r_div == c_div_max) && !pausa;
    assign w_atualiza    = w_tick && !r_morto;
    assign w_acao_valida = (acao != '0) && ((acao & (acao - N_ATRIB'(1))) == '0);
    assign tick          = w_tick;
    assign morto         = r_morto;

    // Tick divider: frozen while paused, keeps running after death.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (!pausa) begin
            r_div <= (r_div == c_div_max) ? '0 : r_div + c_div_w'(1);
        end
    end

    generate
        for (genvar gi = 0; gi < N_ATRIB; gi++) begin : g_canal
            logic [LARGURA-1:0] r_valor;
            logic [LARGURA:0]   w_soma;
            logic [LARGURA-1:0] w_subida;
            logic [LARGURA-1:0] w_descida;
            logic [LARGURA-1:0] w_prox;

            // Rise computed one bit wider so the sum never wraps before the clamp.
            assign w_soma    = {1'b0, r_valor} + c_sub_ext;
            assign w_subida  = (w_soma >= c_max_ext) ? c_max : w_soma[LARGURA-1:0];
            assign w_descida = (r_valor <= c_desc) ? '0 : r_valor - c_desc;
            assign w_prox    = (w_acao_valida && acao[gi]) ? w_subida : w_descida;
            assign w_zero[gi] = (r_valor == '0);
            assign atributos[gi*LARGURA +: LARGURA] = r_valor;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valor <= VAL_INICIAL[gi*LARGURA +: LARGURA];
                end else if (w_atualiza) begin
                    r_valor <= w_prox;
                end
            end

`ifdef ALERTA_HISTERESE_EN
            localparam logic [LARGURA:0] c_lim_hist_ext =
                (LARGURA+1)'(LIMIAR_ALERTA + HIST_ALERTA);
            localparam logic [LARGURA:0] c_ini_ext =
                {1'b0, VAL_INICIAL[gi*LARGURA +: LARGURA]};
            logic r_alerta;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_alerta <= (c_ini_ext < c_lim_ext);
                end else if ({1'b0, r_valor} < c_lim_ext) begin
                    r_alerta <= 1'b1;
                end else if ({1'b0, r_valor} >= c_lim_hist_ext) begin
                    r_alerta <= 1'b0;
                end
            end
            assign alerta[gi] = r_alerta;
`else
            assign alerta[gi] = ({1'b0, r_valor} < c_lim_ext);
`endif
        end
    endgenerate

`ifndef ALERTA_HISTERESE_EN
    logic w_unused_hist;
    assign w_unused_hist = |HIST_ALERTA;
`endif

    // Death counter looks at pre-update values; morto is set on the same edge
    // the counter reaches TICKS_MORTE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cz    <= '0;
            r_morto <= 1'b0;
        end else if (w_atualiza) begin
            if (|w_zero) begin
                if (r_cz < c_ticks) begin
                    r_cz <= r_cz + c_cz_w'(1);
                end
                if (r_cz >= c_ticks_m1) begin
                    r_morto <= 1'b1;
                end
            end else begin
                r_cz <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_atributos_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controlador_atributos_n
//  Description : Directed self-checking bench for controlador_atributos_n.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_atributos_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        r_rst_a = 1'b1, r_rst_b = 1'b1, r_rst_c = 1'b1;
    logic [2:0]  r_acao_a = '0, r_acao_b = '0, r_acao_c = '0;
    logic        r_pausa_a = 1'b0, r_pausa_b = 1'b0, r_pausa_c = 1'b0;
    logic [23:0] w_atr_a, w_atr_b, w_atr_c;
    logic [2:0]  w_alr_a, w_alr_b, w_alr_c;
    logic        w_morto_a, w_morto_b, w_morto_c;
    logic        w_tick_a, w_tick_b, w_tick_c;

    int n_checks = 0;
    int n_errors = 0;

    controlador_atributos_n #(.DIV_TICK(4)) u_dut_a (
        .clk(clk), .rst(r_rst_a), .acao(r_acao_a), .pausa(r_pausa_a),
        .atributos(w_atr_a), .alerta(w_alr_a), .morto(w_morto_a), .tick(w_tick_a));

    controlador_atributos_n #(.DIV_TICK(4), .VAL_INICIAL({8'd2, 8'd70, 8'd80})) u_dut_b (
        .clk(clk), .rst(r_rst_b), .acao(r_acao_b), .pausa(r_pausa_b),
        .atributos(w_atr_b), .alerta(w_alr_b), .morto(w_morto_b), .tick(w_tick_b));

    controlador_atributos_n #(.DIV_TICK(4), .VAL_INICIAL({8'd50, 8'd21, 8'd80})) u_dut_c (
        .clk(clk), .rst(r_rst_c), .acao(r_acao_c), .pausa(r_pausa_c),
        .atributos(w_atr_c), .alerta(w_alr_c), .morto(w_morto_c), .tick(w_tick_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [23:0] exp_a [3];
    logic        r_viu_tick;

    initial begin
        exp_a[0] = {8'd49, 8'd69, 8'd87};
        exp_a[1] = {8'd48, 8'd68, 8'd94};
        exp_a[2] = {8'd47, 8'd67, 8'd100};

        step(2);
        check("rst_atr", {8'h0, w_atr_a}, {8'h0, 8'd50, 8'd70, 8'd80});
        check("rst_alerta", {29'h0, w_alr_a}, 32'd0);
        check("rst_morto", {31'h0, w_morto_a}, 32'd0);
        check("rst_tick", {31'h0, w_tick_a}, 32'd0);

        // Rise of channel 0 over three ticks, saturating on the third.
        r_acao_a = 3'b001; r_rst_a = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(3);
            check("tick_a", {31'h0, w_tick_a}, 32'd1);
            step(1);
            check("sobe_atr", {8'h0, w_atr_a}, {8'h0, exp_a[k]});
        end

        // Illegal and empty actions both decay every channel.
        r_rst_a = 1'b1; step(1); r_rst_a = 1'b0; r_acao_a = 3'b011;
        step(8);
        check("ilegal_atr", {8'h0, w_atr_a}, {8'h0, 8'd48, 8'd68, 8'd78});
        r_rst_a = 1'b1; step(1); r_rst_a = 1'b0; r_acao_a = 3'b000;
        step(8);
        check("zero_atr", {8'h0, w_atr_a}, {8'h0, 8'd48, 8'd68, 8'd78});

        // Pause at divider = 2 for 10 cycles.
        r_rst_a = 1'b1; step(1); r_rst_a = 1'b0;
        step(2);
        r_pausa_a = 1'b1;
        r_viu_tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            r_viu_tick = r_viu_tick | w_tick_a;
        end
        check("pausa_sem_tick", {31'h0, r_viu_tick}, 32'd0);
        check("pausa_atr", {8'h0, w_atr_a}, {8'h0, 8'd50, 8'd70, 8'd80});
        r_pausa_a = 1'b0;
        check("solta_tick0", {31'h0, w_tick_a}, 32'd0);
        step(1);
        check("solta_tick1", {31'h0, w_tick_a}, 32'd1);
        step(1);
        check("solta_atr", {8'h0, w_atr_a}, {8'h0, 8'd49, 8'd69, 8'd79});

        // Reset coincident with a tick wins over the update.
        r_rst_a = 1'b1; step(1); r_rst_a = 1'b0; r_acao_a = 3'b001;
        step(3);
        check("pre_rst_tick", {31'h0, w_tick_a}, 32'd1);
        r_rst_a = 1'b1;
        step(1);
        r_rst_a = 1'b0;
        check("rst_tick_atr", {8'h0, w_atr_a}, {8'h0, 8'd50, 8'd70, 8'd80});
        check("rst_tick_tick", {31'h0, w_tick_a}, 32'd0);

        // Death: sono starts at 2, reaches 0 on tick 2, morto on tick 6.
        r_acao_b = 3'b000;
        check("b_rst_alerta", {29'h0, w_alr_b}, 32'b100);
        r_rst_b = 1'b0;
        step(20);
        check("b_morto_t5", {31'h0, w_morto_b}, 32'd0);
        step(4);
        check("b_morto_t6", {31'h0, w_morto_b}, 32'd1);
        check("b_atr_t6", {8'h0, w_atr_b}, {8'h0, 8'd0, 8'd64, 8'd74});
        check("b_alerta_t6", {29'h0, w_alr_b}, 32'b100);
        step(3);
        check("b_tick_morto", {31'h0, w_tick_b}, 32'd1);
        step(1);
        check("b_atr_congelado", {8'h0, w_atr_b}, {8'h0, 8'd0, 8'd64, 8'd74});
        r_rst_b = 1'b1; step(1); r_rst_b = 1'b0;
        check("b_rst_morto", {31'h0, w_morto_b}, 32'd0);
        check("b_rst_atr", {8'h0, w_atr_b}, {8'h0, 8'd2, 8'd70, 8'd80});

        // Alert threshold around felicidade = 20, then rise back.
        check("c_rst_alerta", {29'h0, w_alr_c}, 32'd0);
        r_rst_c = 1'b0;
        step(5);
        check("c_fel_20", {24'h0, w_atr_c[15:8]}, 32'd20);
        check("c_alerta_20", {29'h0, w_alr_c}, 32'b000);
        step(4);
        check("c_fel_19", {24'h0, w_atr_c[15:8]}, 32'd19);
        check("c_alerta_19", {29'h0, w_alr_c}, 32'b010);
        r_acao_c = 3'b010;
        step(4);
        check("c_fel_26", {24'h0, w_atr_c[15:8]}, 32'd26);
`ifdef ALERTA_HISTERESE_EN
        check("c_alerta_26", {29'h0, w_alr_c}, 32'b010);
`else
        check("c_alerta_26", {29'h0, w_alr_c}, 32'b000);
`endif
        step(4);
        check("c_fel_33", {24'h0, w_atr_c[15:8]}, 32'd33);
        check("c_alerta_33", {29'h0, w_alr_c}, 32'b000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
